eeprom_page_ctrl: RTL and testbench

- Sequencing controller between the I2C byte-level slave front-end and the paged EEPROM storage array (32 pages × 8 bytes).
- Decodes the word-address byte and gathers write bytes into a page buffer with in-page wrap.
- On STOP, commits the buffer to the array as one masked page write, then emulates the write-cycle busy time.
- Serves sequential reads from an auto-incrementing address pointer.

---
 rtl/eeprom_page_ctrl_pkg.sv | 31 +++
 rtl/eeprom_page_ctrl_if.sv | 30 +++
 rtl/eeprom_page_ctrl_page_buf.sv | 43 ++++
 rtl/eeprom_page_ctrl.sv | 139 +++++++++++++
 tb/tb_eeprom_page_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_page_ctrl_pkg.sv
// Shared geometry, state encoding and pointer helpers for the paged EEPROM controller.
package eeprom_pkg;
   localparam int PAGE_NUM   = 32;
   localparam int PAGE_BYTES = 8;
   localparam int ROW_W      = $clog2(PAGE_NUM);
   localparam int COL_W      = $clog2(PAGE_BYTES);
   localparam int PTR_W      = ROW_W + COL_W;
   localparam int PAGE_W     = PAGE_BYTES * 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_COMMIT,
      ST_WRBUSY
   } state_t;

   function automatic logic [ROW_W-1:0] ptr_row(input logic [PTR_W-1:0] ptr);
      return ptr[PTR_W-1:COL_W];
   endfunction

   function automatic logic [COL_W-1:0] ptr_col(input logic [PTR_W-1:0] ptr);
      return ptr[COL_W-1:0];
   endfunction

   function automatic logic [7:0] page_byte(input logic [PAGE_W-1:0] page,
                                            input logic [COL_W-1:0]  col);
      return page[{col, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/eeprom_page_ctrl_if.sv
// Front-end byte handshake plus page-array bus between the I2C slave and the controller.
interface eeprom_page_ctrl_if;
   import eeprom_pkg::*;

   logic                  xfer_start;
   logic                  xfer_rnw;
   logic                  xfer_stop;
   logic                  byte_valid;
   logic [7:0]            byte_in;
   logic                  byte_ack;
   logic                  rd_req;
   logic [7:0]            rd_data;
   logic                  rd_valid;
   logic                  busy;
   logic [ROW_W-1:0]      mem_row;
   logic [PAGE_W-1:0]     mem_wdata;
   logic [PAGE_BYTES-1:0] mem_wmask;
   logic                  mem_write;
   logic [PAGE_W-1:0]     mem_rdata;

   modport slave (
      input  xfer_start, xfer_rnw, xfer_stop, byte_valid, byte_in, rd_req, mem_rdata,
      output byte_ack, rd_data, rd_valid, busy, mem_row, mem_wdata, mem_wmask, mem_write
   );

   modport master (
      output xfer_start, xfer_rnw, xfer_stop, byte_valid, byte_in, rd_req, mem_rdata,
      input  byte_ack, rd_data, rd_valid, busy, mem_row, mem_wdata, mem_wmask, mem_write
   );
endinterface

// File: rtl/eeprom_page_ctrl_page_buf.sv
// Page gather buffer: one byte register and one enable bit per column, flat page output.
module eeprom_page_buf
   import eeprom_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  we,
   input  logic [COL_W-1:0]      waddr,
   input  logic [7:0]            wdata,
   output logic [PAGE_W-1:0]     data,
   output logic [PAGE_BYTES-1:0] mask
);
   for (genvar gi = 0; gi < PAGE_BYTES; gi++) begin : g_byte
      logic [7:0] byte_q, byte_d;
      logic       mask_q, mask_d;
      logic       hit;

      assign hit = we && (waddr == COL_W'(gi));

      always_comb begin
         byte_d = byte_q;
         mask_d = mask_q && !clr;
         if (hit) begin
            byte_d = wdata;
            mask_d = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            byte_q <= '0;
            mask_q <= 1'b0;
         end else begin
            byte_q <= byte_d;
            mask_q <= mask_d;
         end
      end

      assign data[8*gi +: 8] = byte_q;
      assign mask[gi]        = mask_q;
   end
endmodule

// File: rtl/eeprom_page_ctrl.sv
// Sequences I2C byte traffic into masked page writes with emulated write-cycle time,
// and serves sequential reads from a persistent auto-incrementing address pointer.
module eeprom_page_ctrl
   import eeprom_pkg::*;
#(
   parameter int TWR_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   eeprom_page_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(TWR_CYCLES + 1);

   state_t                state_q, state_d;
   state_t                dispatch;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic [7:0]            rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  buf_clr, buf_we;
   logic [PAGE_W-1:0]     buf_data;
   logic [PAGE_BYTES-1:0] buf_mask;
   logic                  commit;

   assign dispatch = bus.xfer_rnw ? ST_RDATA : ST_ADDR;

   eeprom_page_buf u_buf (
      .clk   (clk),
      .reset (reset),
      .clr   (buf_clr),
      .we    (buf_we),
      .waddr (ptr_col(ptr_q)),
      .wdata (bus.byte_in),
      .data  (buf_data),
      .mask  (buf_mask)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      ack_d      = ack_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      buf_clr    = 1'b0;
      buf_we     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.xfer_start) begin
               ack_d   = 1'b1;
               state_d = dispatch;
            end
         end
         ST_ADDR: begin
            if (bus.xfer_start) begin
               ack_d   = 1'b1;
               state_d = dispatch;
            end else if (bus.xfer_stop) begin
               state_d = ST_IDLE;
            end else if (bus.byte_valid) begin
               ptr_d   = bus.byte_in;
               buf_clr = 1'b1;
               ack_d   = 1'b1;
               state_d = ST_WDATA;
            end
         end
         ST_WDATA: begin
            // Repeated start abandons the gathered bytes; ADDR clears the mask on reuse.
            if (bus.xfer_start) begin
               ack_d   = 1'b1;
               state_d = dispatch;
            end else begin
               if (bus.byte_valid) begin
                  buf_we = 1'b1;
                  ptr_d  = {ptr_row(ptr_q), ptr_col(ptr_q) + COL_W'(1)};
                  ack_d  = 1'b1;
               end
               if (bus.xfer_stop)
                  state_d = ((buf_mask != '0) || bus.byte_valid) ? ST_COMMIT : ST_IDLE;
            end
         end
         ST_RDATA: begin
            if (bus.xfer_start) begin
               ack_d   = 1'b1;
               state_d = dispatch;
            end else if (bus.xfer_stop) begin
               state_d = ST_IDLE;
            end else if (bus.rd_req) begin
               rd_data_d  = page_byte(bus.mem_rdata, ptr_col(ptr_q));
               rd_valid_d = 1'b1;
               ptr_d      = ptr_q + PTR_W'(1);
            end
         end
         ST_COMMIT: begin
            if (bus.xfer_start)
               ack_d = 1'b0;
            cnt_d   = CNT_W'(TWR_CYCLES);
            state_d = ST_WRBUSY;
         end
         ST_WRBUSY: begin
            if (bus.xfer_start)
               ack_d = 1'b0;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign commit        = (state_q == ST_COMMIT);
   assign bus.mem_write = commit;
   assign bus.mem_row   = ptr_row(ptr_q);
   assign bus.mem_wdata = commit ? buf_data : '0;
   assign bus.mem_wmask = commit ? buf_mask : '0;
   assign bus.busy      = (state_q == ST_WRBUSY);
   assign bus.byte_ack  = ack_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// Directed bench: plays the I2C front-end and a behavioural page array around eeprom_page_ctrl.
module tb_eeprom_page_ctrl;
   import eeprom_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        preload;
   int          n_vec = 0;
   int          n_err = 0;
   int          write_cnt = 0;
   int          w0;
   int          nb;
   logic [63:0] mem [32];

   eeprom_page_ctrl_if bus();

   eeprom_page_ctrl #(.TWR_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_row];

   // Array model: identity preload (byte at address a holds a), masked page writes.
   always @(posedge clk) begin
      if (preload) begin
         for (int r = 0; r < 32; r++)
            for (int k = 0; k < 8; k++)
               mem[r][8*k +: 8] <= 8'(r * 8 + k);
      end else if (bus.mem_write) begin
         for (int k = 0; k < 8; k++)
            if (bus.mem_wmask[k])
               mem[bus.mem_row][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
         write_cnt <= write_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] expand(input logic [7:0] m);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++)
         if (m[k]) r[8*k +: 8] = 8'hFF;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic rnw);
      bus.xfer_start = 1'b1;
      bus.xfer_rnw   = rnw;
      cyc();
      bus.xfer_start = 1'b0;
      bus.xfer_rnw   = 1'b0;
      $display("tx start rnw=%0b ack=%0b busy=%0b", rnw, bus.byte_ack, bus.busy);
   endtask

   task automatic send(input logic [7:0] b, input logic with_stop);
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      bus.xfer_stop  = with_stop;
      cyc();
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      bus.xfer_stop  = 1'b0;
      $display("tx byte 0x%02h stop=%0b ack=%0b", b, with_stop, bus.byte_ack);
   endtask

   task automatic stop();
      bus.xfer_stop = 1'b1;
      cyc();
      bus.xfer_stop = 1'b0;
      $display("tx stop write=%0b", bus.mem_write);
   endtask

   task automatic rd(input string tag, input logic [7:0] exp);
      bus.rd_req = 1'b1;
      cyc();
      bus.rd_req = 1'b0;
      $display("tx read 0x%02h valid=%0b", bus.rd_data, bus.rd_valid);
      check({tag, " rd_valid"}, 64'(bus.rd_valid), 64'd1);
      check({tag, " rd_data"}, 64'(bus.rd_data), 64'(exp));
      cyc();
      check({tag, " rd_valid pulse"}, 64'(bus.rd_valid), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " byte_ack"}, 64'(bus.byte_ack), 64'd0);
      check({tag, " rd_valid"}, 64'(bus.rd_valid), 64'd0);
      check({tag, " rd_data"}, 64'(bus.rd_data), 64'd0);
      check({tag, " busy"}, 64'(bus.busy), 64'd0);
      check({tag, " mem_write"}, 64'(bus.mem_write), 64'd0);
      check({tag, " mem_row"}, 64'(bus.mem_row), 64'd0);
      check({tag, " mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
      check({tag, " mem_wdata"}, bus.mem_wdata, 64'd0);
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (bus.busy) n++;
         else if (n > 0) break;
      end
   endtask

   initial begin
      reset          = 1'b1;
      preload        = 1'b1;
      bus.xfer_start = 1'b0;
      bus.xfer_rnw   = 1'b0;
      bus.xfer_stop  = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      bus.rd_req     = 1'b0;
      repeat (3) cyc();
      preload = 1'b0;
      check_zero_outputs("reset");
      reset = 1'b0;
      cyc();

      // Page write 0x12 <- A0 A1 A2
      w0 = write_cnt;
      xfer(1'b0);
      check("t1 start ack", 64'(bus.byte_ack), 64'd1);
      send(8'h12, 1'b0);
      send(8'hA0, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      stop();
      check("t1 mem_write", 64'(bus.mem_write), 64'd1);
      check("t1 mem_row", 64'(bus.mem_row), 64'd2);
      check("t1 mem_wmask", 64'(bus.mem_wmask), 64'h1C);
      check("t1 mem_wdata", bus.mem_wdata & expand(8'h1C), 64'h000000A2A1A00000);
      wait_busy(nb);
      check("t1 busy cycles", 64'(nb), 64'd16);
      check("t1 write count", 64'(write_cnt - w0), 64'd1);
      check("t1 row2", mem[2], 64'h171615A2A1A01110);
      xfer(1'b1);
      rd("t1 ptr", 8'h15);
      stop();

      // In-page wrap from 0x06, last byte arrives together with STOP
      w0 = write_cnt;
      xfer(1'b0);
      send(8'h06, 1'b0);
      send(8'hB0, 1'b0);
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hB3, 1'b1);
      check("t2 mem_write", 64'(bus.mem_write), 64'd1);
      check("t2 mem_row", 64'(bus.mem_row), 64'd0);
      check("t2 mem_wmask", 64'(bus.mem_wmask), 64'hC3);
      check("t2 mem_wdata", bus.mem_wdata & expand(8'hC3), 64'hB1B000000000B3B2);
      cyc();
      check("t2 row0", mem[0], 64'hB1B005040302B3B2);
      check("t3 busy", 64'(bus.busy), 64'd1);

      // ACK polling while the write cycle runs
      xfer(1'b0);
      check("t3 poll nack", 64'(bus.byte_ack), 64'd0);
      check("t3 poll still busy", 64'(bus.busy), 64'd1);
      send(8'h77, 1'b0);
      check("t3 byte ignored ack", 64'(bus.byte_ack), 64'd0);
      wait_busy(nb);
      check("t3 remaining busy", 64'(nb), 64'd13);
      xfer(1'b0);
      check("t3 ack after twr", 64'(bus.byte_ack), 64'd1);
      stop();
      check("t3 write count", 64'(write_cnt - w0), 64'd1);

      // Dummy write sets pointer, then sequential read across 0xFF -> 0x00
      preload = 1'b1;
      cyc();
      preload = 1'b0;
      w0 = write_cnt;
      xfer(1'b0);
      send(8'hFE, 1'b0);
      stop();
      check("t4 dummy no write", 64'(bus.mem_write), 64'd0);
      cyc();
      check("t4 dummy not busy", 64'(bus.busy), 64'd0);
      xfer(1'b1);
      check("t4 read ack", 64'(bus.byte_ack), 64'd1);
      rd("t4 r0", 8'hFE);
      rd("t4 r1", 8'hFF);
      rd("t4 r2", 8'h00);
      stop();
      check("t4 write count", 64'(write_cnt - w0), 64'd0);

      // Repeated start discards buffered write bytes
      w0 = write_cnt;
      xfer(1'b0);
      send(8'h40, 1'b0);
      send(8'hC0, 1'b0);
      send(8'hC1, 1'b0);
      xfer(1'b1);
      check("t5 rs ack", 64'(bus.byte_ack), 64'd1);
      rd("t5 r0", 8'h42);
      rd("t5 r1", 8'h43);
      stop();
      check("t5 write count", 64'(write_cnt - w0), 64'd0);

      // Reset in the middle of a page write
      w0 = write_cnt;
      xfer(1'b0);
      send(8'h5B, 1'b0);
      send(8'hD0, 1'b0);
      send(8'hD1, 1'b0);
      send(8'hD2, 1'b0);
      reset = 1'b1;
      cyc();
      check_zero_outputs("t6 reset");
      reset = 1'b0;
      repeat (3) cyc();
      check("t6 write count", 64'(write_cnt - w0), 64'd0);
      xfer(1'b1);
      rd("t6 r0", 8'h00);
      rd("t6 r1", 8'h01);
      stop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
